byte_pack: RTL and testbench
============================

BYTE_PACK -- requirements
Module: byte_pack

Interface
REQ-001 SHALL have a single clock: clk, input, 1 bit; all state changes on its rising edge.
REQ-002 SHALL have rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have din, input, 8 bits: input data byte.
REQ-004 SHALL have din_vld, input, 1 bit: din is valid this cycle; there is no backpressure, so every valid byte is taken.
REQ-005 SHALL have din_sop, input, 1 bit: din is the first byte of a packet; qualified by din_vld.
REQ-006 SHALL have din_eop, input, 1 bit: din is the last byte of a packet; qualified by din_vld.
REQ-007 SHALL have dout, output, 32 bits: packed word; byte k sits at bits [8k+7:8k], and byte 0 is the first byte received.
REQ-008 SHALL have dout_vld, output, 1 bit: dout is valid; a single-cycle pulse per word.
REQ-009 SHALL have dout_sop, output, 1 bit: this word is the first word of a packet.
REQ-010 SHALL have dout_eop, output, 1 bit: this word is the last word of a packet.
REQ-011 SHALL have dout_mty, output, 2 bits: number of empty upper bytes in the eop word; 0 when dout_eop=0.

Function
REQ-012 SHALL use a two-state FSM: IDLE (no packet open) and BUSY (packet open); plus lane counter cnt (2 bits, 0..3) and a 24-bit holding register for lanes 0..2.
REQ-013 In IDLE, din_vld=1 and din_sop=1: byte goes to lane 0, cnt becomes 1, state becomes BUSY, and the first-word flag is set.
REQ-014 In IDLE, din_vld=1 and din_sop=0: byte is discarded and state/cnt are unchanged (protocol error).
REQ-015 In BUSY, din_vld=1 and din_sop=0: byte goes to lane cnt; cnt increments and wraps 3 to 0.
REQ-016 A word SHALL be emitted when a byte lands in lane 3, or when din_eop=1 is accepted; dout_vld rises on the next clk edge (latency 1 cycle).
REQ-017 On eop: dout_mty = 3 - lane of the eop byte; unused upper lanes = 8'h00; cnt cleared to 0; state becomes IDLE.
REQ-018 dout_sop SHALL be 1 only on the first emitted word of a packet, and is cleared after that word.
REQ-019 din_sop=1 together with din_eop=1 in IDLE: one word emitted with dout_sop=1, dout_eop=1, dout_mty=3, dout[31:8]=0; state stays IDLE.
REQ-020 din_sop=1 in BUSY: accumulated partial lanes are discarded without being emitted, and the new packet starts per REQ-013 (protocol error).
REQ-021 din_vld=0: no state change, and dout_vld=0 on the next cycle.
REQ-022 Packet length SHALL be unbounded; cnt wraps freely, and only eop or sop terminates a packet.

Reset
REQ-023 While rst_n=0, the following SHALL apply: dout=0, dout_vld=0, dout_sop=0, dout_eop=0, dout_mty=0, state=IDLE, cnt=0, holding register=0.
REQ-024 Reset mid-packet SHALL discard the partial word; no word is emitted for it after release.

Configuration
REQ-025 Macro BYTE_PACK_ERR_EN, when defined, SHALL add output port err (1 bit, reset 0), which pulses for one cycle, aligned with where dout_vld would appear, for each REQ-014 or REQ-020 event.
REQ-026 Without BYTE_PACK_ERR_EN, the err port and its logic SHALL be absent; data-path behaviour SHALL be identical.

Structure
REQ-027 Shared package byte_pack_pkg SHALL hold: the lane count (4), byte width (8), word width (32), mty width (2), and the FSM state enum (IDLE, BUSY).
REQ-028 SHALL be a single module; no sub-module is required.

Verification
REQ-029 Stimulus: 8-byte packet 01..08, sop on 01, eop on 08, back-to-back. Required response: words 32'h04030201 (sop=1, eop=0) and 32'h08070605 (sop=0, eop=1, mty=0).
REQ-030 Stimulus: 5-byte packet A1..A5. Required response: 32'hA4A3A2A1 (sop=1), then 32'h000000A5 (eop=1, mty=3).
REQ-031 Stimulus: 1-byte packet 5C with sop=eop=1. Required response: one word 32'h0000005C with sop=1, eop=1, mty=3.
REQ-032 Stimulus: 6-byte packet with din_vld gaps of 0..3 cycles between bytes. Required response: the same two words as the gapless case, each dout_vld 1 cycle after its completing byte.
REQ-033 Stimulus: bytes 11,22 (sop on 11), then sop on 33, then bytes 44,55 with eop on 55. Required response: only 32'h00554433 (sop=1, eop=1, mty=1); err pulses once if BYTE_PACK_ERR_EN is defined.
REQ-034 Stimulus: rst_n asserted after 2 bytes of a packet, then a new 4-byte packet. Required response: all outputs 0 during reset, and only the new packet's word is emitted.

Source files
------------

// File: rtl/byte_pack_pkg.sv
// rtl/byte_pack_pkg.sv - shared widths, FSM state type and lane-packing helper for byte_pack
package byte_pack_pkg;

    localparam int LANES  = 4;
    localparam int BYTE_W = 8;
    localparam int WORD_W = LANES * BYTE_W;
    localparam int MTY_W  = 2;
    localparam int HOLD_W = (LANES - 1) * BYTE_W;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Lanes below 'lane' come from the holding register, 'lane' takes the new byte, upper lanes are zero.
    function automatic logic [WORD_W-1:0] pack_word(input logic [HOLD_W-1:0] hold,
                                                     input logic [MTY_W-1:0]  lane,
                                                     input logic [BYTE_W-1:0] b);
        logic [WORD_W-1:0] padded;
        logic [WORD_W-1:0] w;
        padded = {{BYTE_W{1'b0}}, hold};
        w      = '0;
        for (int k = 0; k < LANES; k++) begin
            if (k < int'(lane)) begin
                w[k*BYTE_W +: BYTE_W] = padded[k*BYTE_W +: BYTE_W];
            end else if (k == int'(lane)) begin
                w[k*BYTE_W +: BYTE_W] = b;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/byte_pack.sv
// rtl/byte_pack.sv - packs a byte stream into 32-bit words with sop/eop/mty; optional err output under BYTE_PACK_ERR_EN
module byte_pack
    import byte_pack_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] din,
    input  logic              din_vld,
    input  logic              din_sop,
    input  logic              din_eop,
    output logic [WORD_W-1:0] dout,
    output logic              dout_vld,
    output logic              dout_sop,
    output logic              dout_eop,
    output logic [MTY_W-1:0]  dout_mty
`ifdef BYTE_PACK_ERR_EN
    ,
    output logic              err
`endif
);

    state_t              state_q, state_d;
    logic [MTY_W-1:0]    cnt_q, cnt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                first_q, first_d;

    logic [WORD_W-1:0]   dout_q, dout_d;
    logic                dout_vld_q, dout_vld_d;
    logic                dout_sop_q, dout_sop_d;
    logic                dout_eop_q, dout_eop_d;
    logic [MTY_W-1:0]    dout_mty_q, dout_mty_d;

    logic                start;
    logic                take;
    logic [MTY_W-1:0]    lane;
    logic                emit;
    logic                proto_err;

    // A sop always restarts at lane 0, abandoning any partial word.
    assign start     = din_vld && din_sop;
    assign take      = din_vld && !din_sop && (state_q == BUSY);
    assign lane      = start ? '0 : cnt_q;
    assign emit      = (start || take) && (din_eop || (lane == MTY_W'(LANES - 1)));
    assign proto_err = din_vld && (((state_q == IDLE) && !din_sop) || ((state_q == BUSY) && din_sop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hold_q     <= '0;
            first_q    <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            dout_sop_q <= 1'b0;
            dout_eop_q <= 1'b0;
            dout_mty_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            first_q    <= first_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            dout_sop_q <= dout_sop_d;
            dout_eop_q <= dout_eop_d;
            dout_mty_q <= dout_mty_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        first_d = first_q;
        if (start) begin
            hold_d  = '0;
            first_d = 1'b0;
            if (din_eop) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d            = BUSY;
                cnt_d              = MTY_W'(1);
                hold_d[BYTE_W-1:0] = din;
                first_d            = 1'b1;
            end
        end else if (take) begin
            if (emit) begin
                hold_d  = '0;
                first_d = 1'b0;
            end else begin
                hold_d[{cnt_q, 3'b000} +: BYTE_W] = din;
            end
            if (din_eop) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + MTY_W'(1);
            end
        end
    end

    always_comb begin
        dout_d     = '0;
        dout_vld_d = 1'b0;
        dout_sop_d = 1'b0;
        dout_eop_d = 1'b0;
        dout_mty_d = '0;
        if (emit) begin
            dout_d     = pack_word(hold_q, lane, din);
            dout_vld_d = 1'b1;
            dout_sop_d = start || first_q;
            dout_eop_d = din_eop;
            dout_mty_d = din_eop ? (MTY_W'(LANES - 1) - lane) : '0;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign dout_sop = dout_sop_q;
    assign dout_eop = dout_eop_q;
    assign dout_mty = dout_mty_q;

`ifdef BYTE_PACK_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= proto_err;
        end
    end

    assign err = err_q;
`else
    logic unused_err;
    assign unused_err = proto_err;
`endif

endmodule

// File: tb/tb_byte_pack.sv
// tb/tb_byte_pack.sv - self-checking bench for byte_pack with a packet-level reference model
module tb_byte_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  din;
    logic        din_vld;
    logic        din_sop;
    logic        din_eop;
    logic [31:0] dout;
    logic        dout_vld;
    logic        dout_sop;
    logic        dout_eop;
    logic [1:0]  dout_mty;
`ifdef BYTE_PACK_ERR_EN
    logic        err;
`endif

    byte_pack dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .din_vld  (din_vld),
        .din_sop  (din_sop),
        .din_eop  (din_eop),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_sop (dout_sop),
        .dout_eop (dout_eop),
        .dout_mty (dout_mty)
`ifdef BYTE_PACK_ERR_EN
        ,
        .err      (err)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: bytes of the open packet, flushed as a word when four are held or on eop.
    logic [7:0]  pkt[$];
    bit          in_pkt = 0;
    bit          first  = 0;
    bit          nxt_vld, nxt_sop, nxt_eop;
    logic [31:0] nxt_word;
    logic [1:0]  nxt_mty;

    bit          exp_rst = 1;
    bit          exp_vld = 0, exp_sop = 0, exp_eop = 0;
    logic [31:0] exp_word = '0;
    logic [1:0]  exp_mty = '0;

    logic [36:0] dut_log[$];

    task automatic model_step(input bit v, input logic [7:0] d, input bit s, input bit e);
        nxt_vld = 0; nxt_sop = 0; nxt_eop = 0; nxt_word = '0; nxt_mty = '0;
        if (!v) return;
        if (s) begin
            pkt.delete();
            in_pkt = 1;
            first  = 1;
        end else if (!in_pkt) begin
            return;
        end
        pkt.push_back(d);
        if (pkt.size() == 4 || e) begin
            nxt_vld = 1;
            for (int i = 0; i < pkt.size(); i++) nxt_word[8*i +: 8] = pkt[i];
            nxt_sop = first;
            nxt_eop = e;
            nxt_mty = e ? 2'(4 - pkt.size()) : 2'd0;
            first   = 0;
            pkt.delete();
            if (e) in_pkt = 0;
        end
    endtask

    task automatic cyc(input bit v, input logic [7:0] d, input bit s, input bit e);
        din_vld = v; din = d; din_sop = s; din_eop = e;
        model_step(v, d, s, e);
        @(posedge clk);
        #1;
        exp_vld = nxt_vld; exp_sop = nxt_sop; exp_eop = nxt_eop;
        exp_word = nxt_word; exp_mty = nxt_mty;
        din_vld = 0; din_sop = 0; din_eop = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 0;
        pkt.delete();
        in_pkt = 0; first = 0;
        exp_rst = 1; exp_vld = 0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1;
        exp_rst = 0;
        exp_vld = 0; exp_sop = 0; exp_eop = 0; exp_word = '0; exp_mty = '0;
    endtask

    always @(negedge clk) begin
        n_vec++;
        if (exp_rst) begin
            if ({dout, dout_vld, dout_sop, dout_eop, dout_mty} !== 37'd0) begin
                n_err++;
                $display("FAIL reset_outputs: got dout=%h vld=%b sop=%b eop=%b mty=%0d, want all zero",
                         dout, dout_vld, dout_sop, dout_eop, dout_mty);
            end
        end else if (dout_vld !== exp_vld) begin
            n_err++;
            $display("FAIL dout_vld @%0t: got %b want %b", $time, dout_vld, exp_vld);
        end else if (exp_vld) begin
            dut_log.push_back({dout, dout_sop, dout_eop, dout_mty});
            if ({dout, dout_sop, dout_eop, dout_mty} !== {exp_word, exp_sop, exp_eop, exp_mty}) begin
                n_err++;
                $display("FAIL word @%0t: got %h sop=%b eop=%b mty=%0d, want %h sop=%b eop=%b mty=%0d",
                         $time, dout, dout_sop, dout_eop, dout_mty, exp_word, exp_sop, exp_eop, exp_mty);
            end
        end
    end

    task automatic pin(input string nm, input int idx, input logic [31:0] w, input bit s, input bit e,
                       input logic [1:0] m);
        logic [36:0] want;
        want = {w, s, e, m};
        n_vec++;
        if (idx >= dut_log.size()) begin
            n_err++;
            $display("FAIL %s: word %0d missing, got %0d words, want %h", nm, idx, dut_log.size(), w);
        end else if (dut_log[idx] !== want) begin
            n_err++;
            $display("FAIL %s: word %0d got %h want %h", nm, idx, dut_log[idx], want);
        end
    endtask

    task automatic pin_count(input string nm, input int n);
        n_vec++;
        if (dut_log.size() != n) begin
            n_err++;
            $display("FAIL %s_count: got %0d words want %0d", nm, dut_log.size(), n);
        end
        dut_log.delete();
    endtask

    initial begin
        logic [7:0] gb[6];
        int         gaps[5];
        rst_n = 0; din = 0; din_vld = 0; din_sop = 0; din_eop = 0;
        do_reset(3);
        idle(2);
        dut_log.delete();

        // 8 bytes back-to-back
        for (int i = 1; i <= 8; i++) cyc(1, 8'(i), i == 1, i == 8);
        idle(2);
        pin("pkt8_w0", 0, 32'h04030201, 1, 0, 2'd0);
        pin("pkt8_w1", 1, 32'h08070605, 0, 1, 2'd0);
        pin_count("pkt8", 2);

        // 5 bytes A1..A5
        for (int i = 1; i <= 5; i++) cyc(1, 8'hA0 + 8'(i), i == 1, i == 5);
        idle(2);
        pin("pkt5_w0", 0, 32'hA4A3A2A1, 1, 0, 2'd0);
        pin("pkt5_w1", 1, 32'h000000A5, 0, 1, 2'd3);
        pin_count("pkt5", 2);

        // single byte packet
        cyc(1, 8'h5C, 1, 1);
        idle(2);
        pin("pkt1_w0", 0, 32'h0000005C, 1, 1, 2'd3);
        pin_count("pkt1", 1);

        // 6 bytes with 0..3 idle gaps
        gb = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6};
        gaps = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 6; i++) begin
            cyc(1, gb[i], i == 0, i == 5);
            if (i < 5) idle(gaps[i]);
        end
        idle(2);
        pin("gap_w0", 0, 32'hB4B3B2B1, 1, 0, 2'd0);
        pin("gap_w1", 1, 32'h0000B6B5, 0, 1, 2'd2);
        pin_count("gap", 2);

        // stray byte in IDLE is discarded
        cyc(1, 8'h77, 0, 0);
        cyc(1, 8'h78, 0, 1);
        idle(2);
        pin_count("stray", 0);

        // sop in mid-packet restarts
        cyc(1, 8'h11, 1, 0);
        cyc(1, 8'h22, 0, 0);
        cyc(1, 8'h33, 1, 0);
        cyc(1, 8'h44, 0, 0);
        cyc(1, 8'h55, 0, 1);
        idle(2);
        pin("resop_w0", 0, 32'h00554433, 1, 1, 2'd1);
        pin_count("resop", 1);

        // 9 bytes: middle word carries neither sop nor eop
        for (int i = 0; i < 9; i++) cyc(1, 8'hC0 + 8'(i), i == 0, i == 8);
        idle(2);
        pin("pkt9_w0", 0, 32'hC3C2C1C0, 1, 0, 2'd0);
        pin("pkt9_w1", 1, 32'hC7C6C5C4, 0, 0, 2'd0);
        pin("pkt9_w2", 2, 32'h000000C8, 0, 1, 2'd3);
        pin_count("pkt9", 3);

        // reset mid-packet, then a fresh 4-byte packet
        cyc(1, 8'hD1, 1, 0);
        cyc(1, 8'hD2, 0, 0);
        do_reset(2);
        idle(1);
        for (int i = 0; i < 4; i++) cyc(1, 8'hE1 + 8'(i), i == 0, i == 3);
        idle(2);
        pin("rst_w0", 0, 32'hE4E3E2E1, 1, 1, 2'd0);
        pin_count("rst", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
